// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage.
package mem_stage_pkg;

  localparam int unsigned EXE_MEM_W = 110;
  localparam int unsigned MEM_WB_W  = 69;

  // EXE_MEM_BUS field offsets: {through[15:0], alu_data[31:0], out_data[31:0], pc[29:0]}
  localparam int unsigned IN_PC_LO  = 0;
  localparam int unsigned IN_OUT_LO = 30;
  localparam int unsigned IN_ALU_LO = 62;
  localparam int unsigned IN_TH_LO  = 94;

  // through-field bit positions
  localparam int unsigned TH_MEM_EN  = 15;
  localparam int unsigned TH_MEM_WE  = 14;
  localparam int unsigned TH_SIZE_LO = 12;
  localparam int unsigned TH_SIGN    = 11;
  localparam int unsigned TH_WB_EN   = 10;
  localparam int unsigned TH_DST_LO  = 5;

  // access size encodings
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_align.sv
// Store lane replication / byte enables, load lane extract / extend and
// misalignment detection. Purely combinational.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] ld_data,
  output logic        misaligned
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = ld_word[{addr_lo, 3'b000} +: 8];
  assign ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

  // Format per access size; the unused size code 2'b11 behaves as a word.
  always_comb begin
    st_wdata   = st_data;
    st_be      = 4'b1111;
    ld_data    = ld_word;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        st_wdata = {4{st_data[7:0]}};
        st_be    = 4'b0001 << addr_lo;
        ld_data  = {{24{sign_ext & ld_byte[7]}}, ld_byte};
      end
      SZ_H: begin
        st_wdata   = {2{st_data[15:0]}};
        st_be      = addr_lo[1] ? 4'b1100 : 4'b0011;
        ld_data    = {{16{sign_ext & ld_half[15]}}, ld_half};
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: accepts EXE_MEM_BUS, performs loads/stores
// over a req/ack data-memory port, and presents a registered MEM_WB_BUS.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned BUS_IN_W  = EXE_MEM_W,
  parameter int unsigned BUS_OUT_W = MEM_WB_W
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 exe_valid,
  output logic                 exe_ready,
  input  logic [BUS_IN_W-1:0]  EXE_MEM_BUS,
  input  logic                 flush,
  output logic                 dm_req,
  output logic                 dm_we,
  output logic [29:0]          dm_addr,
  output logic [31:0]          dm_wdata,
  output logic [3:0]           dm_be,
  input  logic                 dm_ack,
  input  logic [31:0]          dm_rdata,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [BUS_OUT_W-1:0] MEM_WB_BUS
);

  state_e      state;
  logic        kill;

  logic [15:0] in_thr;
  logic [31:0] in_alu;
  logic [31:0] in_out;
  logic [29:0] in_pc;
  logic        in_mem_en;
  logic        in_we;
  logic [1:0]  in_size;
  logic        in_sign;
  logic        in_wb_en;
  logic [4:0]  in_dst;
  logic        unused_thr_bits;

  logic [1:0]  lat_size;
  logic        lat_sign;
  logic [1:0]  lat_addr_lo;
  logic        lat_wb_en;
  logic [4:0]  lat_dst;
  logic [29:0] lat_pc;

  logic [1:0]  al_size;
  logic [1:0]  al_addr_lo;
  logic        al_sign;
  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic [31:0] al_ld;
  logic        al_mis;
  logic [31:0] ld_result;
  logic        accept;

  assign in_thr    = EXE_MEM_BUS[IN_TH_LO  +: 16];
  assign in_alu    = EXE_MEM_BUS[IN_ALU_LO +: 32];
  assign in_out    = EXE_MEM_BUS[IN_OUT_LO +: 32];
  assign in_pc     = EXE_MEM_BUS[IN_PC_LO  +: 30];
  assign in_mem_en = in_thr[TH_MEM_EN];
  assign in_we     = in_thr[TH_MEM_WE];
  assign in_size   = in_thr[TH_SIZE_LO +: 2];
  assign in_sign   = in_thr[TH_SIGN];
  assign in_wb_en  = in_thr[TH_WB_EN];
  assign in_dst    = in_thr[TH_DST_LO +: 5];
  assign unused_thr_bits = ^in_thr[4:0];

  assign exe_ready = (state == IDLE) || ((state == DONE) && wb_ready);
  assign accept    = exe_valid && !flush && exe_ready;

  // One aligner serves both paths: REQ formats load data from the latched
  // instruction, otherwise it checks/prepares the incoming one.
  assign al_size    = (state == REQ) ? lat_size    : in_size;
  assign al_addr_lo = (state == REQ) ? lat_addr_lo : in_alu[1:0];
  assign al_sign    = (state == REQ) ? lat_sign    : in_sign;

  // Stores have no write-back data.
  assign ld_result  = dm_we ? 32'h0 : al_ld;

  mem_align u_align (
    .size       (al_size),
    .addr_lo    (al_addr_lo),
    .sign_ext   (al_sign),
    .st_data    (in_out),
    .ld_word    (dm_rdata),
    .st_wdata   (al_wdata),
    .st_be      (al_be),
    .ld_data    (al_ld),
    .misaligned (al_mis)
  );

  // Stage FSM with registered memory-port and write-back outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      kill        <= 1'b0;
      dm_req      <= 1'b0;
      dm_we       <= 1'b0;
      dm_addr     <= '0;
      dm_wdata    <= '0;
      dm_be       <= '0;
      wb_valid    <= 1'b0;
      MEM_WB_BUS  <= '0;
      lat_size    <= '0;
      lat_sign    <= 1'b0;
      lat_addr_lo <= '0;
      lat_wb_en   <= 1'b0;
      lat_dst     <= '0;
      lat_pc      <= '0;
    end else begin
      case (state)
        IDLE: begin
        end
        REQ: begin
          if (flush) kill <= 1'b1;
          if (dm_ack) begin
            dm_req <= 1'b0;
            dm_we  <= 1'b0;
            dm_be  <= '0;
            kill   <= 1'b0;
            if (kill || flush) begin
              state <= IDLE;
            end else begin
              wb_valid   <= 1'b1;
              MEM_WB_BUS <= {lat_wb_en, lat_dst, ld_result, lat_pc, 1'b0};
              state      <= DONE;
            end
          end
        end
        DONE: begin
          if (flush || (wb_ready && !exe_valid)) begin
            wb_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Accept is shared by IDLE and DONE (same-cycle handoff); it is placed
      // after the case so its assignments take precedence.
      if (accept) begin
        lat_size    <= in_size;
        lat_sign    <= in_sign;
        lat_addr_lo <= in_alu[1:0];
        lat_wb_en   <= in_wb_en;
        lat_dst     <= in_dst;
        lat_pc      <= in_pc;
        if (in_mem_en && al_mis) begin
          wb_valid   <= 1'b1;
          MEM_WB_BUS <= {1'b0, in_dst, 32'h0, in_pc, 1'b1};
          state      <= DONE;
        end else if (in_mem_en) begin
          wb_valid <= 1'b0;
          dm_req   <= 1'b1;
          dm_we    <= in_we;
          dm_addr  <= in_alu[31:2];
          dm_wdata <= al_wdata;
          dm_be    <= al_be;
          state    <= REQ;
        end else begin
          wb_valid   <= 1'b1;
          MEM_WB_BUS <= {in_wb_en, in_dst, in_alu, in_pc, 1'b0};
          state      <= DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         exe_valid = 1'b0;
  logic         exe_ready;
  logic [109:0] EXE_MEM_BUS = '0;
  logic         flush = 1'b0;
  logic         dm_req;
  logic         dm_we;
  logic [29:0]  dm_addr;
  logic [31:0]  dm_wdata;
  logic [3:0]   dm_be;
  logic         dm_ack = 1'b0;
  logic [31:0]  dm_rdata = '0;
  logic         wb_valid;
  logic         wb_ready = 1'b1;
  logic [68:0]  MEM_WB_BUS;

  mem_stage dut (
    .clk         (clk),
    .resetn      (resetn),
    .exe_valid   (exe_valid),
    .exe_ready   (exe_ready),
    .EXE_MEM_BUS (EXE_MEM_BUS),
    .flush       (flush),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_be       (dm_be),
    .dm_ack      (dm_ack),
    .dm_rdata    (dm_rdata),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .MEM_WB_BUS  (MEM_WB_BUS)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [68:0] exp;
    logic [68:0] mask;
  } sb_t;

  sb_t sbq[$];
  int  n_checks   = 0;
  int  n_errors   = 0;
  int  n_pushed   = 0;
  int  n_handoffs = 0;

  localparam logic [68:0] FULL      = '1;
  localparam logic [68:0] DATA_MASK = {1'b1, 5'h1f, 32'h0, 30'h3fffffff, 1'b1};

  task automatic check(input string tag, input logic [68:0] act, input logic [68:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] mk_thr(input logic mem_en, input logic we, input logic [1:0] size,
                                         input logic sign, input logic wb_en, input logic [4:0] dst);
    return {mem_en, we, size, sign, wb_en, dst, 5'h1f};
  endfunction

  function automatic logic [109:0] mk_bus(input logic [15:0] thr, input logic [31:0] alu,
                                          input logic [31:0] od, input logic [29:0] pc);
    return {thr, alu, od, pc};
  endfunction

  function automatic logic [68:0] mk_wb(input logic en, input logic [4:0] dst, input logic [31:0] d,
                                        input logic [29:0] pc, input logic err);
    return {en, dst, d, pc, err};
  endfunction

  task automatic expect_wb(input logic [68:0] e, input logic [68:0] m);
    sbq.push_back('{e, m});
    n_pushed++;
  endtask

  task automatic issue(input logic [109:0] b);
    @(negedge clk);
    EXE_MEM_BUS = b;
    exe_valid   = 1'b1;
  endtask

  // Called right after issue(): N cycles of dm_req, ack in the N-th.
  task automatic mem_op(input int unsigned n, input logic [31:0] rdata, input logic we,
                        input logic [29:0] addr, input logic [3:0] be, input logic [31:0] wdata,
                        input string tag);
    for (int unsigned i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == 1) exe_valid = 1'b0;
      check({tag, "_req"}, dm_req, 1);
      check({tag, "_we"}, dm_we, we);
      check({tag, "_addr"}, dm_addr, addr);
      check({tag, "_be"}, dm_be, be);
      if (we) check({tag, "_wdata"}, dm_wdata, wdata);
      check({tag, "_no_wb_yet"}, wb_valid, 0);
      if (i == n) begin
        dm_ack   = 1'b1;
        dm_rdata = rdata;
      end
    end
    @(negedge clk);
    dm_ack   = 1'b0;
    dm_rdata = '0;
    check({tag, "_req_drop"}, dm_req, 0);
    check({tag, "_wb_valid"}, wb_valid, 1);
    @(negedge clk);
    check({tag, "_wb_drop"}, wb_valid, 0);
  endtask

  task automatic misaligned_case(input logic [109:0] b, input logic [4:0] dst,
                                 input logic [29:0] pc, input string tag);
    issue(b);
    expect_wb(mk_wb(1'b0, dst, 32'h0, pc, 1'b1), DATA_MASK);
    @(negedge clk);
    exe_valid = 1'b0;
    check({tag, "_wb_valid"}, wb_valid, 1);
    check({tag, "_no_req"}, dm_req, 0);
    @(negedge clk);
    check({tag, "_wb_drop"}, wb_valid, 0);
    check({tag, "_no_req2"}, dm_req, 0);
  endtask

  // Write-back monitor: each valid cycle is compared with the scoreboard head,
  // which also proves the bus holds steady while stalled.
  always @(negedge clk) begin
    #1;
    if (resetn && wb_valid) begin
      if (sbq.size() == 0) begin
        check("wb_unexpected", wb_valid, 0);
      end else begin
        check(wb_ready ? "wb_handoff" : "wb_stall_hold",
              MEM_WB_BUS & sbq[0].mask, sbq[0].exp & sbq[0].mask);
        if (wb_ready) begin
          void'(sbq.pop_front());
          n_handoffs++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_dm_req", dm_req, 0);
    check("rst_dm_we", dm_we, 0);
    check("rst_dm_be", dm_be, 0);
    check("rst_dm_addr", dm_addr, 0);
    check("rst_dm_wdata", dm_wdata, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_mem_wb_bus", MEM_WB_BUS, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_exe_ready", exe_ready, 1);

    // ALU passthrough
    issue(mk_bus(mk_thr(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd3), 32'h12345678, 32'hDEADBEEF, 30'h100));
    expect_wb(mk_wb(1'b1, 5'd3, 32'h12345678, 30'h100, 1'b0), FULL);
    #1 check("alu_exe_ready", exe_ready, 1);
    @(negedge clk);
    exe_valid = 1'b0;
    check("alu_lat1_valid", wb_valid, 1);
    check("alu_no_req", dm_req, 0);
    @(negedge clk);
    check("alu_wb_drop", wb_valid, 0);
    check("alu_no_req2", dm_req, 0);

    // Byte store at 0x103, 3-cycle ack
    issue(mk_bus(mk_thr(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 5'd9), 32'h00000103, 32'h123456AB, 30'h200));
    expect_wb(mk_wb(1'b0, 5'd9, 32'h0, 30'h200, 1'b0), DATA_MASK);
    mem_op(3, 32'h55555555, 1'b1, 30'h40, 4'b1000, 32'hABABABAB, "sb");

    // Half loads at 0x202, signed then unsigned
    issue(mk_bus(mk_thr(1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 5'd5), 32'h00000202, 32'h0, 30'h201));
    expect_wb(mk_wb(1'b1, 5'd5, 32'hFFFF8001, 30'h201, 1'b0), FULL);
    mem_op(2, 32'h80017FFF, 1'b0, 30'h80, 4'b1100, 32'h0, "lh");
    issue(mk_bus(mk_thr(1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 5'd6), 32'h00000202, 32'h0, 30'h202));
    expect_wb(mk_wb(1'b1, 5'd6, 32'h00008001, 30'h202, 1'b0), FULL);
    mem_op(2, 32'h80017FFF, 1'b0, 30'h80, 4'b1100, 32'h0, "lhu");

    // Signed byte load lane 1, single-cycle ack
    issue(mk_bus(mk_thr(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 5'd10), 32'h00000001, 32'h0, 30'h203));
    expect_wb(mk_wb(1'b1, 5'd10, 32'hFFFFFF80, 30'h203, 1'b0), FULL);
    mem_op(1, 32'h12348056, 1'b0, 30'h0, 4'b0010, 32'h0, "lb");

    // Word load
    issue(mk_bus(mk_thr(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd11), 32'h000003FC, 32'h0, 30'h204));
    expect_wb(mk_wb(1'b1, 5'd11, 32'hCAFEF00D, 30'h204, 1'b0), FULL);
    mem_op(1, 32'hCAFEF00D, 1'b0, 30'hFF, 4'b1111, 32'h0, "lw");

    // Misaligned accesses
    misaligned_case(mk_bus(mk_thr(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd7), 32'h00000301, 32'h0, 30'h300),
                    5'd7, 30'h300, "mis_lw");
    misaligned_case(mk_bus(mk_thr(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 5'd8), 32'h00000105, 32'h0, 30'h301),
                    5'd8, 30'h301, "mis_sh");

    // Backpressure then back-to-back throughput
    wb_ready = 1'b0;
    issue(mk_bus(mk_thr(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd1), 32'hA0000001, 32'h0, 30'h400));
    expect_wb(mk_wb(1'b1, 5'd1, 32'hA0000001, 30'h400, 1'b0), FULL);
    @(negedge clk);
    EXE_MEM_BUS = mk_bus(mk_thr(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd2), 32'hB0000002, 32'h0, 30'h401);
    expect_wb(mk_wb(1'b1, 5'd2, 32'hB0000002, 30'h401, 1'b0), FULL);
    #1 check("bp_exe_ready_low", exe_ready, 0);
    check("bp_wb_valid", wb_valid, 1);
    repeat (3) begin
      @(negedge clk);
      #1 check("bp_exe_ready_hold", exe_ready, 0);
    end
    @(negedge clk);
    wb_ready = 1'b1;
    #1 check("bp_exe_ready_follow", exe_ready, 1);
    @(negedge clk);
    EXE_MEM_BUS = mk_bus(mk_thr(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd3), 32'hC0000003, 32'h0, 30'h402);
    expect_wb(mk_wb(1'b1, 5'd3, 32'hC0000003, 30'h402, 1'b0), FULL);
    check("bp_b2b_valid", wb_valid, 1);
    @(negedge clk);
    EXE_MEM_BUS = mk_bus(mk_thr(1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 5'd4), 32'hD0000004, 32'h0, 30'h403);
    expect_wb(mk_wb(1'b0, 5'd4, 32'hD0000004, 30'h403, 1'b0), FULL);
    @(negedge clk);
    exe_valid = 1'b0;
    @(negedge clk);
    check("bp_idle_after", wb_valid, 0);
    check("bp_sb_empty", 69'(sbq.size()), 0);
    check("bp_count", 69'(n_handoffs), 69'(n_pushed));

    // Flush while holding a result
    wb_ready = 1'b0;
    issue(mk_bus(mk_thr(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd12), 32'hE000000E, 32'h0, 30'h500));
    expect_wb(mk_wb(1'b1, 5'd12, 32'hE000000E, 30'h500, 1'b0), FULL);
    @(negedge clk);
    exe_valid = 1'b0;
    flush     = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    void'(sbq.pop_front());
    n_pushed--;
    check("fl_done_drop", wb_valid, 0);
    wb_ready = 1'b1;
    #1 check("fl_done_ready", exe_ready, 1);

    // Flush together with exe_valid in IDLE: nothing accepted
    issue(mk_bus(mk_thr(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd13), 32'h00000600, 32'h0, 30'h501));
    flush = 1'b1;
    @(negedge clk);
    exe_valid = 1'b0;
    flush     = 1'b0;
    check("fl_idle_no_req", dm_req, 0);
    check("fl_idle_no_wb", wb_valid, 0);

    // Flush during REQ: transaction completes, result dropped
    issue(mk_bus(mk_thr(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd14), 32'h00000400, 32'h0, 30'h502));
    @(negedge clk);
    exe_valid = 1'b0;
    check("fl_req_up", dm_req, 1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    EXE_MEM_BUS = mk_bus(mk_thr(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd15), 32'hF000000F, 32'h0, 30'h503);
    exe_valid = 1'b1;
    check("fl_req_hold1", dm_req, 1);
    #1 check("fl_req_not_ready1", exe_ready, 0);
    @(negedge clk);
    check("fl_req_hold2", dm_req, 1);
    check("fl_req_no_wb", wb_valid, 0);
    #1 check("fl_req_not_ready2", exe_ready, 0);
    @(negedge clk);
    dm_ack   = 1'b1;
    dm_rdata = 32'h11112222;
    check("fl_req_hold3", dm_req, 1);
    #1 check("fl_req_not_ready3", exe_ready, 0);
    @(negedge clk);
    dm_ack    = 1'b0;
    exe_valid = 1'b0;
    check("fl_req_drop", dm_req, 0);
    check("fl_req_discard", wb_valid, 0);
    #1 check("fl_req_ready_again", exe_ready, 1);
    @(negedge clk);
    check("fl_req_discard2", wb_valid, 0);

    // Asynchronous reset mid-REQ
    issue(mk_bus(mk_thr(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd16), 32'h00000500, 32'h0, 30'h504));
    @(negedge clk);
    exe_valid = 1'b0;
    check("arst_req_up", dm_req, 1);
    #2 resetn = 1'b0;
    #1 check("arst_req_drop", dm_req, 0);
    check("arst_be_clear", dm_be, 0);
    check("arst_wb_valid", wb_valid, 0);
    @(negedge clk);
    resetn = 1'b1;
    #1 check("arst_exe_ready", exe_ready, 1);
    @(negedge clk);
    check("arst_no_req", dm_req, 0);

    // Stage still works after reset
    issue(mk_bus(mk_thr(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd17), 32'h5A5A5A5A, 32'h0, 30'h505));
    expect_wb(mk_wb(1'b1, 5'd17, 32'h5A5A5A5A, 30'h505, 1'b0), FULL);
    @(negedge clk);
    exe_valid = 1'b0;
    check("post_rst_valid", wb_valid, 1);
    @(negedge clk);
    check("sb_drained", 69'(sbq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage. Sits directly downstream of the execute stage and consumes its 110-bit EXE_MEM_BUS.
- Performs loads and stores through a request/acknowledge data-memory port.
- Registers the write-back result onto a 69-bit MEM_WB_BUS with a valid/ready handshake toward write-back.
- Handles multi-cycle memory latency, misaligned-access detection and pipeline flush.

Parameters:
- BUS_IN_W, 110, width of EXE_MEM_BUS; fixed.
- BUS_OUT_W, 69, width of MEM_WB_BUS; fixed.

Ports:
- clk  input  1  single clock, rising edge
- resetn  input  1  asynchronous active-low reset
- exe_valid  input  1  EXE_MEM_BUS holds a valid instruction
- exe_ready  output  1  stage can accept this cycle
- EXE_MEM_BUS  input  110  {through[15:0], alu_data[31:0], out_data[31:0], pc[29:0]}
- flush  input  1  kill all in-flight work (exception/redirect)
- dm_req  output  1  data-memory request
- dm_we  output  1  1=store, 0=load
- dm_addr  output  30  word address = alu_data[31:2]
- dm_wdata  output  32  store data, lane-replicated
- dm_be  output  4  byte enables
- dm_ack  input  1  request complete; dm_rdata valid for loads
- dm_rdata  input  32  load word
- wb_valid  output  1  MEM_WB_BUS valid
- wb_ready  input  1  write-back accepts
- MEM_WB_BUS  output  69  {wb_en, wb_dst[4:0], wb_data[31:0], pc[29:0], addr_err}

Behaviour:
- through field decode:
  - [15] mem_en, [14] mem_we, [13:12] size (00 byte, 01 half, 10 word), [11] load sign-extend, [10] wb_en, [9:5] wb_dst.
  - [4:0] reserved, ignored.
- Address = alu_data; store data = out_data.
- FSM states:
  - IDLE: exe_ready=1. Accept on exe_valid&&!flush.
    - Misaligned access (half with addr[0]=1, or word with addr[1:0]!=0): no memory access; MEM_WB gets addr_err=1, wb_en=0; go DONE.
    - mem_en=1 and aligned: go REQ.
    - mem_en=0: wb_data=alu_data; go DONE.
  - REQ: dm_req=1. dm_we/addr/wdata/be held stable from the latched instruction until dm_ack. On dm_ack: capture and format load data, go DONE.
  - DONE: wb_valid=1, MEM_WB_BUS stable. exe_ready=wb_ready, giving back-to-back throughput.
    - wb_ready && exe_valid: handoff and re-accept in the same cycle.
    - wb_ready && !exe_valid: go IDLE.
- Latency from accept to wb_valid:
  - non-memory op: 1 cycle.
  - memory op: 1 + N cycles, where dm_ack arrives N cycles after dm_req rises (N≥1).
- Store lanes:
  - byte: wdata={4{b}}, be=1<<addr[1:0].
  - half: wdata={2{h}}, be=addr[1]?1100:0011.
  - word: be=1111.
- Load: select lane by addr[1:0]; zero- or sign-extend per bit 11. wb_data = formatted load data.
- Flush:
  - IDLE: nothing accepted that cycle.
  - DONE: wb_valid drops next cycle; go IDLE.
  - REQ: the bus transaction is not aborted. dm_req stays high until dm_ack; a kill flag is set; the result is discarded on ack; go IDLE. exe_ready=0 until then.
  - flush and exe_valid in the same cycle: flush wins, no accept.
- Reset: state=IDLE. dm_req=0, dm_we=0, dm_be=0, dm_addr=0, dm_wdata=0. wb_valid=0, MEM_WB_BUS=0, kill=0. exe_ready=1 after reset release. Reset asserted mid-REQ abandons the transaction immediately.
- No combinational path from dm_ack/dm_rdata to MEM_WB_BUS. exe_ready may depend combinationally on wb_ready.

Decomposition:
- Shared package holds:
  - through-field bit positions.
  - size encodings (SZ_B, SZ_H, SZ_W).
  - FSM state localparams (IDLE, REQ, DONE).
  - bus width constants.
- One sub-module, mem_align: combinational store lane/byte-enable generation, load extract/extend and misalignment check. Shared by the REQ and IDLE paths.

Test Plan:
- ALU passthrough: alu_data=0x12345678, wb_en=1, dst=3, mem_en=0 -> wb_valid 1 cycle after accept, wb_data=0x12345678, dm_req never asserted.
- Byte store: addr=0x103, out_data=0xAB, size=00 -> dm_req, dm_addr=0x40, dm_be=1000, dm_wdata=0xABABABAB held through 3-cycle ack delay; wb_en=0.
- Signed half load: addr=0x202, sign=1, dm_rdata=0x8001_7FFF, ack after 2 cycles -> wb_data=0xFFFF8001. Repeat with sign=0 -> 0x00008001.
- Misaligned word load: addr=0x301 -> no dm_req, wb_valid next cycle, addr_err=1, wb_en=0.
- Backpressure/throughput: wb_ready=0 for 4 cycles, then three back-to-back ALU ops -> MEM_WB_BUS stable while stalled; then one result per cycle, none lost or duplicated.
- Flush in REQ: assert flush 1 cycle after dm_req rises, ack 3 cycles later -> dm_req held until ack, no wb_valid, exe_ready=0 until IDLE. Async resetn low mid-REQ -> dm_req=0 immediately.
